keypad_scanner: RTL

Front-end for the vending-machine controller's 4x4 membrane keypad.
- Drives the keypad rows one at a time and samples the column lines.
- Debounces and qualifies a single key press.
- Presents the key to the downstream control FSM as the active-low column/row pair `c[3:0]` / `r[3:0]` it decodes (e.g. `c[0]=0`, `r[0]=0` = chips; `c[1]=0`, `r[0]=0` = coffee).
- Sits between the board keypad pins and the vending FSM.

---
 rtl/keypad_scanner.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 membrane keypad front-end for the vending controller.
// Walks an active-low row strobe across the keypad, samples the column lines through a
// 2-flop synchronizer and debounces one key press/release on a slow scan tick. Accepted
// keys are presented as active-low column/row one-cold levels plus a binary code.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   col_in     raw column lines, active-low, asynchronous to clk
//   row_drive  row strobe, active-low, exactly one bit low
//   c, r       debounced column/row of the held key, active-low, 4'b1111 when idle
//   key_valid  high while an accepted key is held
//   key_press  one-cycle pulse on acceptance
//   key_code   {row, col} of the last accepted key
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_drive,
  output logic [3:0] c,
  output logic [3:0] r,
  output logic       key_valid,
  output logic       key_press,
  output logic [3:0] key_code
);

  localparam int unsigned DivW  = $clog2(SCAN_DIV);
  localparam int unsigned StabW = $clog2(DEBOUNCE + 1);
  localparam logic [DivW-1:0]  DivMax  = DivW'(SCAN_DIV - 1);
  localparam logic [StabW-1:0] StabMax = StabW'(DEBOUNCE);
  localparam logic [StabW-1:0] StabOne = StabW'(1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e           state_q, state_d;
  logic [3:0]       col_meta_q, col_s_q;
  logic [DivW-1:0]  div_q, div_d;
  logic [StabW-1:0] stab_q, stab_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       row_drive_q, row_drive_d;
  logic [1:0]       cand_row_q, cand_row_d;
  logic [1:0]       cand_col_q, cand_col_d;
  logic [3:0]       c_q, c_d;
  logic [3:0]       r_q, r_d;
  logic             valid_q, valid_d;
  logic             press_q, press_d;
  logic [3:0]       code_q, code_d;

  logic             tick;
  logic             single;
  logic [1:0]       single_idx;
  logic [3:0]       cand_pat;
  logic [StabW-1:0] stab_inc;

  assign tick     = (div_q == DivMax);
  assign div_d    = tick ? '0 : div_q + 1'b1;
  assign cand_pat = ~(4'b0001 << cand_col_q);
  assign stab_inc = (stab_q < StabMax) ? stab_q + 1'b1 : stab_q;

  // Exactly one column low; multi-key patterns are treated as no key.
  always_comb begin
    single     = 1'b1;
    single_idx = 2'd0;
    case (col_s_q)
      4'b1110: single_idx = 2'd0;
      4'b1101: single_idx = 2'd1;
      4'b1011: single_idx = 2'd2;
      4'b0111: single_idx = 2'd3;
      default: single     = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    stab_d     = stab_q;
    row_d      = row_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    c_d        = c_q;
    r_d        = r_q;
    valid_d    = valid_q;
    press_d    = 1'b0;
    code_d     = code_q;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (single) begin
            cand_row_d = row_q;
            cand_col_d = single_idx;
            stab_d     = StabOne;
            state_d    = StDebounce;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        StDebounce: begin
          if (col_s_q == cand_pat) begin
            stab_d = stab_inc;
            if (stab_inc == StabMax) begin
              state_d = StHeld;
              c_d     = cand_pat;
              r_d     = ~(4'b0001 << cand_row_q);
              valid_d = 1'b1;
              press_d = 1'b1;
              code_d  = {cand_row_q, cand_col_q};
            end
          end else begin
            state_d = StScan;
            row_d   = row_q + 2'd1;
          end
        end
        StHeld: begin
          // Only the accepted column matters; other keys on this row are ignored.
          if (col_s_q[cand_col_q]) begin
            stab_d  = StabOne;
            state_d = StRelease;
          end
        end
        StRelease: begin
          if (col_s_q[cand_col_q]) begin
            stab_d = stab_inc;
            if (stab_inc == StabMax) begin
              state_d = StScan;
              row_d   = row_q + 2'd1;
              c_d     = 4'b1111;
              r_d     = 4'b1111;
              valid_d = 1'b0;
            end
          end else begin
            // Bounce during release: back to held without a new press pulse.
            state_d = StHeld;
            stab_d  = '0;
          end
        end
        default: state_d = StScan;
      endcase
    end
    row_drive_d = ~(4'b0001 << row_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StScan;
      col_meta_q  <= 4'b1111;
      col_s_q     <= 4'b1111;
      div_q       <= '0;
      stab_q      <= '0;
      row_q       <= 2'd0;
      row_drive_q <= 4'b1110;
      cand_row_q  <= 2'd0;
      cand_col_q  <= 2'd0;
      c_q         <= 4'b1111;
      r_q         <= 4'b1111;
      valid_q     <= 1'b0;
      press_q     <= 1'b0;
      code_q      <= 4'h0;
    end else begin
      state_q     <= state_d;
      col_meta_q  <= col_in;
      col_s_q     <= col_meta_q;
      div_q       <= div_d;
      stab_q      <= stab_d;
      row_q       <= row_d;
      row_drive_q <= row_drive_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      c_q         <= c_d;
      r_q         <= r_d;
      valid_q     <= valid_d;
      press_q     <= press_d;
      code_q      <= code_d;
    end
  end

  assign row_drive = row_drive_q;
  assign c         = c_q;
  assign r         = r_q;
  assign key_valid = valid_q;
  assign key_press = press_q;
  assign key_code  = code_q;

endmodule
